acq_readout_sequencer: RTL and testbench

ACQ_READOUT_SEQUENCER -- requirements
Module: acq_readout_sequencer

---
 rtl/acq_readout_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_acq_readout_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_readout_sequencer.sv
// Arms a bank of acquisition channels, waits for every enabled buffer to fill,
// then reads a window of samples from each channel out over an AXI-Stream port.
module acq_readout_sequencer #(
    parameter int NCHAN           = 4,
    parameter int BUFFER_CAPACITY = 32768,
    parameter int READ_LATENCY    = 3
) (
    input  logic                 sysClk,
    input  logic                 sysReset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCHAN-1:0]     chanEnable,
    input  logic [30:0]          readStart,
    input  logic [23:0]          readCount,
    input  logic [31:0]          timeoutLimit,
    output logic [31:0]          GPIO_OUT,
    output logic [NCHAN-1:0]     sysCsrStrobe,
    input  logic [32*NCHAN-1:0]  sysStatus,
    input  logic [32*NCHAN-1:0]  sysData,
    output logic [31:0]          m_tdata,
    output logic [2:0]           m_tuser,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 timedOut,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, ARM = 3'd1, WAIT_FULL = 3'd2, ADDR = 3'd3,
        LATENCY = 3'd4, OUTPUT = 3'd5, DISARM = 3'd6, DONE = 3'd7
    } seqState_t;

    localparam int          LW       = $clog2(READ_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);
    localparam logic [30:0] IDX_MASK = 31'(BUFFER_CAPACITY - 1);

    seqState_t        cur;
    logic [NCHAN-1:0] enLat;
    logic [30:0]      startLat;
    logic [23:0]      countLat;
    logic [31:0]      toLat;
    logic [31:0]      timer;
    logic [LW-1:0]    latCnt;
    logic [2:0]       chan;
    logic [30:0]      index;
    logic [23:0]      remaining;
    logic             toPending;

    logic             allFull;
    logic             hasNext;
    logic [2:0]       firstChan;
    logic [2:0]       nextChan;
    logic [31:0]      curData;
    logic [30:0]      idxInc;

    assign state  = cur;
    assign idxInc = (index + 31'd1) & IDX_MASK;

    function automatic logic [NCHAN-1:0] oneHot(input logic [2:0] c);
        return NCHAN'(1) << c;
    endfunction

    // Descending scan so the lowest qualifying channel wins.
    always_comb begin
        allFull   = 1'b1;
        hasNext   = 1'b0;
        firstChan = 3'd0;
        nextChan  = 3'd0;
        curData   = 32'd0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (enLat[i] && !sysStatus[32*i + 30]) allFull = 1'b0;
            if (enLat[i]) firstChan = 3'(i);
            if (enLat[i] && 3'(i) > chan) begin
                nextChan = 3'(i);
                hasNext  = 1'b1;
            end
            if (chan == 3'(i)) curData = sysData[32*i +: 32];
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            cur          <= IDLE;
            GPIO_OUT     <= '0;
            sysCsrStrobe <= '0;
            m_tdata      <= '0;
            m_tuser      <= '0;
            m_tlast      <= 1'b0;
            m_tvalid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timedOut     <= 1'b0;
            toPending    <= 1'b0;
            enLat        <= '0;
            startLat     <= '0;
            countLat     <= '0;
            toLat        <= '0;
            timer        <= '0;
            latCnt       <= '0;
            chan         <= '0;
            index        <= '0;
            remaining    <= '0;
        end else begin
            sysCsrStrobe <= '0;
            done         <= 1'b0;
            if (abort && cur != IDLE && cur != DISARM) begin
                cur          <= DISARM;
                m_tvalid     <= 1'b0;
                GPIO_OUT     <= 32'd0;
                sysCsrStrobe <= enLat;
            end else begin
                unique case (cur)
                    IDLE: if (start) begin
                        enLat <= chanEnable;
                        busy  <= 1'b1;
                        if (chanEnable != '0) begin
                            startLat     <= readStart;
                            countLat     <= readCount;
                            toLat        <= timeoutLimit;
                            timedOut     <= 1'b0;
                            toPending    <= 1'b0;
                            GPIO_OUT     <= 32'h8000_0000;
                            sysCsrStrobe <= chanEnable;
                            cur          <= ARM;
                        end else begin
                            cur <= DONE;
                        end
                    end
                    ARM: begin
                        timer <= '0;
                        cur   <= WAIT_FULL;
                    end
                    WAIT_FULL: begin
                        timer <= timer + 32'd1;
                        // Status may still show the previous fill right after arming.
                        if (timer >= 32'd2 && allFull) begin
                            if (countLat == '0) begin
                                cur <= DONE;
                            end else begin
                                chan         <= firstChan;
                                index        <= startLat;
                                remaining    <= countLat;
                                GPIO_OUT     <= {1'b0, startLat};
                                sysCsrStrobe <= oneHot(firstChan);
                                cur          <= ADDR;
                            end
                        end else if (toLat != '0 && timer == toLat) begin
                            timedOut     <= 1'b1;
                            toPending    <= 1'b1;
                            GPIO_OUT     <= 32'd0;
                            sysCsrStrobe <= enLat;
                            cur          <= DISARM;
                        end
                    end
                    ADDR: begin
                        latCnt <= '0;
                        cur    <= LATENCY;
                    end
                    LATENCY: begin
                        if (latCnt == LAT_LAST) begin
                            m_tdata  <= curData;
                            m_tuser  <= chan;
                            m_tlast  <= (remaining == 24'd1);
                            m_tvalid <= 1'b1;
                            cur      <= OUTPUT;
                        end else begin
                            latCnt <= latCnt + LW'(1);
                        end
                    end
                    OUTPUT: if (m_tready) begin
                        m_tvalid  <= 1'b0;
                        index     <= idxInc;
                        remaining <= remaining - 24'd1;
                        if (remaining != 24'd1) begin
                            GPIO_OUT     <= {1'b0, idxInc};
                            sysCsrStrobe <= oneHot(chan);
                            cur          <= ADDR;
                        end else if (hasNext) begin
                            chan         <= nextChan;
                            index        <= startLat;
                            remaining    <= countLat;
                            GPIO_OUT     <= {1'b0, startLat};
                            sysCsrStrobe <= oneHot(nextChan);
                            cur          <= ADDR;
                        end else begin
                            cur <= DONE;
                        end
                    end
                    DISARM: begin
                        done      <= toPending;
                        toPending <= 1'b0;
                        busy      <= 1'b0;
                        cur       <= IDLE;
                    end
                    DONE: begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        cur  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Directed bench for acq_readout_sequencer with a latency-accurate channel model.
module tb_acq_readout_sequencer;

    localparam int NCHAN = 4;
    localparam int CAP   = 32768;
    localparam int RL    = 3;

    logic                sysClk = 1'b0;
    logic                sysReset_n = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                m_tready = 1'b0;
    logic [NCHAN-1:0]    chanEnable = '0;
    logic [30:0]         readStart = '0;
    logic [23:0]         readCount = '0;
    logic [31:0]         timeoutLimit = '0;
    logic [NCHAN-1:0]    fullBits = '0;
    logic [31:0]         GPIO_OUT;
    logic [NCHAN-1:0]    sysCsrStrobe;
    logic [32*NCHAN-1:0] sysStatus;
    logic [32*NCHAN-1:0] sysData;
    logic [31:0]         m_tdata;
    logic [2:0]          m_tuser;
    logic                m_tlast, m_tvalid, busy, done, timedOut;
    logic [2:0]          state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    acq_readout_sequencer #(.NCHAN(NCHAN), .BUFFER_CAPACITY(CAP), .READ_LATENCY(RL)) dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start), .abort(abort),
        .chanEnable(chanEnable), .readStart(readStart), .readCount(readCount),
        .timeoutLimit(timeoutLimit), .GPIO_OUT(GPIO_OUT), .sysCsrStrobe(sysCsrStrobe),
        .sysStatus(sysStatus), .sysData(sysData), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
        .done(done), .timedOut(timedOut), .state(state)
    );

    always #5 sysClk = ~sysClk;
    always @(posedge sysClk) cyc <= cyc + 1;

    // Channel model: data for an address is only valid READ_LATENCY cycles after its strobe.
    logic [23:0] chAddr [NCHAN] = '{default: 24'd0};
    int          chAge  [NCHAN] = '{default: 0};
    always @(negedge sysClk) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (sysCsrStrobe[i]) begin
                chAddr[i] <= GPIO_OUT[23:0];
                chAge[i]  <= 1;
            end else if (chAge[i] != 0 && chAge[i] <= RL) begin
                chAge[i] <= chAge[i] + 1;
            end
        end
    end
    always_comb begin
        sysStatus = '0;
        sysData   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            sysStatus[32*i +: 32] = {1'b0, fullBits[i], 30'd0};
            sysData[32*i +: 32]   = (chAge[i] > RL) ? {4'hA, 4'(i), chAddr[i]} : 32'hDEAD_BEEF;
        end
    end

    // Transaction logs.
    logic [NCHAN-1:0] stbQ[$];
    logic [31:0]      gpioQ[$];
    logic [2:0]       stQ[$];
    logic [31:0]      datQ[$];
    logic [2:0]       usrQ[$];
    logic             lastQ[$];
    int               beatCyc[$];
    int               doneCnt = 0;
    always @(negedge sysClk) begin
        if (sysCsrStrobe != '0) begin
            stbQ.push_back(sysCsrStrobe);
            gpioQ.push_back(GPIO_OUT);
            stQ.push_back(state);
        end
        if (m_tvalid && m_tready) begin
            datQ.push_back(m_tdata);
            usrQ.push_back(m_tuser);
            lastQ.push_back(m_tlast);
            beatCyc.push_back(cyc);
        end
        if (done) doneCnt <= doneCnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic doReset();
        start = 0; abort = 0; m_tready = 0; chanEnable = '0; readStart = '0;
        readCount = '0; timeoutLimit = '0; fullBits = '0;
        sysReset_n = 0;
        repeat (2) @(posedge sysClk);
        #1 sysReset_n = 1;
        @(posedge sysClk); #1;
    endtask

    task automatic pulseStart();
        start = 1;
        @(posedge sysClk); #1 start = 0;
    endtask

    task automatic waitState(input logic [2:0] s, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge sysClk);
            if (state == s) ok = 1;
        end
    endtask

    task automatic waitDone(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge sysClk);
            if (done) ok = 1;
        end
        @(posedge sysClk); #1;
    endtask

    task automatic test_reset();
        start = 1; chanEnable = 4'b0011;
        #3 sysReset_n = 0;
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (timedOut !== 1'b0) begin failures++; $display("FAIL reset_timedOut got=%0b exp=0", timedOut); end
        checks++; if (GPIO_OUT !== 32'd0) begin failures++; $display("FAIL reset_gpio got=%0h exp=0", GPIO_OUT); end
        checks++; if (sysCsrStrobe !== 4'd0) begin failures++; $display("FAIL reset_strobe got=%0b exp=0", sysCsrStrobe); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", m_tvalid); end
        checks++; if (m_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%0h exp=0", m_tdata); end
        checks++; if (m_tuser !== 3'd0) begin failures++; $display("FAIL reset_tuser got=%0d exp=0", m_tuser); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0b exp=0", m_tlast); end
        repeat (3) @(posedge sysClk);
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_hold_state got=%0d exp=0", state); end
        doReset();
    endtask

    task automatic test_basic();
        bit ok;
        int sb, bb, d0;
        logic [31:0] expD;
        doReset();
        chanEnable = 4'b0101; readStart = 31'd10; readCount = 24'd3; m_tready = 1;
        sb = stbQ.size(); bb = datQ.size(); d0 = doneCnt;
        pulseStart();
        waitState(3'd1, 5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_arm_reached got=0 exp=1"); end
        checks++; if (sysCsrStrobe !== 4'b0101) begin failures++; $display("FAIL basic_arm_strobe got=%0b exp=0101", sysCsrStrobe); end
        checks++; if (GPIO_OUT !== 32'h8000_0000) begin failures++; $display("FAIL basic_arm_gpio got=%0h exp=80000000", GPIO_OUT); end
        repeat (5) @(posedge sysClk);
        #1 fullBits = '1;
        waitDone(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_done_seen got=0 exp=1"); end
        checks++; if (stbQ.size() - sb !== 7) begin failures++; $display("FAIL basic_strobe_count got=%0d exp=7", stbQ.size() - sb); end
        if (stbQ.size() - sb >= 7) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (gpioQ[sb+1+k] !== 32'(10 + k % 3) || stbQ[sb+1+k] !== (k < 3 ? 4'b0001 : 4'b0100)
                    || stQ[sb+1+k] !== 3'd3) begin
                    failures++;
                    $display("FAIL basic_addr%0d got=%0h/%0b/%0d exp=%0h/%0b/3", k, gpioQ[sb+1+k],
                             stbQ[sb+1+k], stQ[sb+1+k], 10 + k % 3, (k < 3 ? 4'b0001 : 4'b0100));
                end
            end
        end
        checks++; if (datQ.size() - bb !== 6) begin failures++; $display("FAIL basic_beat_count got=%0d exp=6", datQ.size() - bb); end
        if (datQ.size() - bb >= 6) begin
            for (int k = 0; k < 6; k++) begin
                expD = 32'hA000_0000 | ((k < 3 ? 32'd0 : 32'd2) << 24) | 32'(10 + k % 3);
                checks++;
                if (datQ[bb+k] !== expD || usrQ[bb+k] !== (k < 3 ? 3'd0 : 3'd2)
                    || lastQ[bb+k] !== (k == 2 || k == 5)) begin
                    failures++;
                    $display("FAIL basic_beat%0d got=%0h/%0d/%0b exp=%0h/%0d/%0b", k, datQ[bb+k], usrQ[bb+k],
                             lastQ[bb+k], expD, (k < 3 ? 0 : 2), (k == 2 || k == 5));
                end
            end
            for (int k = 1; k < 6; k++) begin
                checks++;
                if (beatCyc[bb+k] - beatCyc[bb+k-1] < RL + 2) begin
                    failures++;
                    $display("FAIL basic_gap%0d got=%0d exp>=%0d", k, beatCyc[bb+k] - beatCyc[bb+k-1], RL + 2);
                end
            end
        end
        checks++; if (doneCnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", doneCnt - d0); end
        checks++; if (timedOut !== 1'b0) begin failures++; $display("FAIL basic_timedOut got=%0b exp=0", timedOut); end
    endtask

    task automatic test_wrap();
        bit ok;
        int sb, bb;
        doReset();
        chanEnable = 4'b0001; readStart = 31'(CAP - 1); readCount = 24'd2; fullBits = '1; m_tready = 1;
        sb = stbQ.size(); bb = datQ.size();
        pulseStart();
        waitDone(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_done_seen got=0 exp=1"); end
        checks++; if (stbQ.size() - sb !== 3) begin failures++; $display("FAIL wrap_strobe_count got=%0d exp=3", stbQ.size() - sb); end
        checks++; if (datQ.size() - bb !== 2) begin failures++; $display("FAIL wrap_beat_count got=%0d exp=2", datQ.size() - bb); end
        if (stbQ.size() - sb >= 3 && datQ.size() - bb >= 2) begin
            checks++; if (gpioQ[sb+1] !== 32'd32767) begin failures++; $display("FAIL wrap_addr0 got=%0d exp=32767", gpioQ[sb+1]); end
            checks++; if (gpioQ[sb+2] !== 32'd0) begin failures++; $display("FAIL wrap_addr1 got=%0d exp=0", gpioQ[sb+2]); end
            checks++; if (datQ[bb] !== 32'hA000_7FFF || lastQ[bb] !== 1'b0) begin failures++; $display("FAIL wrap_beat0 got=%0h/%0b exp=a0007fff/0", datQ[bb], lastQ[bb]); end
            checks++; if (datQ[bb+1] !== 32'hA000_0000 || lastQ[bb+1] !== 1'b1) begin failures++; $display("FAIL wrap_beat1 got=%0h/%0b exp=a0000000/1", datQ[bb+1], lastQ[bb+1]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t0, d0;
        doReset();
        chanEnable = 4'b0011; readCount = 24'd1; timeoutLimit = 32'd100;
        d0 = doneCnt;
        pulseStart();
        waitState(3'd2, 5, ok);
        t0 = cyc;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge sysClk);
            if (timedOut) ok = 1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL timeout_seen got=0 exp=1"); end
        checks++; if (cyc - t0 < 98 || cyc - t0 > 104) begin failures++; $display("FAIL timeout_cycles got=%0d exp=~100", cyc - t0); end
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL timeout_disarm_state got=%0d exp=6", state); end
        checks++; if (sysCsrStrobe !== 4'b0011) begin failures++; $display("FAIL timeout_disarm_strobe got=%0b exp=0011", sysCsrStrobe); end
        checks++; if (GPIO_OUT !== 32'd0) begin failures++; $display("FAIL timeout_disarm_gpio got=%0h exp=0", GPIO_OUT); end
        @(negedge sysClk);
        checks++; if (done !== 1'b1 || state !== 3'd0) begin failures++; $display("FAIL timeout_done_idle got=%0b/%0d exp=1/0", done, state); end
        repeat (4) @(posedge sysClk);
        #1;
        checks++; if (timedOut !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%0b exp=1", timedOut); end
        checks++; if (doneCnt - d0 !== 1) begin failures++; $display("FAIL timeout_done_count got=%0d exp=1", doneCnt - d0); end
    endtask

    task automatic test_stall();
        bit ok;
        int sbs, bb;
        doReset();
        chanEnable = 4'b0010; readStart = 31'd5; readCount = 24'd2; fullBits = '1; m_tready = 0;
        bb = datQ.size();
        pulseStart();
        waitState(3'd5, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_output_reached got=0 exp=1"); end
        sbs = stbQ.size();
        for (int k = 0; k < 20; k++) begin
            @(negedge sysClk);
            checks++;
            if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 3'd1, 32'hA100_0005}) begin
                failures++;
                $display("FAIL stall_hold%0d got=%0b/%0d/%0h exp=1/1/a1000005", k, m_tvalid, m_tuser, m_tdata);
            end
        end
        @(posedge sysClk); #1;
        checks++; if (stbQ.size() !== sbs) begin failures++; $display("FAIL stall_no_strobe got=%0d exp=%0d", stbQ.size(), sbs); end
        m_tready = 1;
        waitDone(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_done_seen got=0 exp=1"); end
        checks++; if (datQ.size() - bb !== 2) begin failures++; $display("FAIL stall_beat_count got=%0d exp=2", datQ.size() - bb); end
        if (datQ.size() - bb >= 2) begin
            checks++; if (datQ[bb+1] !== 32'hA100_0006 || lastQ[bb+1] !== 1'b1) begin failures++; $display("FAIL stall_beat1 got=%0h/%0b exp=a1000006/1", datQ[bb+1], lastQ[bb+1]); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int sb, bb, d0;
        doReset();
        chanEnable = 4'b1001; readCount = 24'd4; fullBits = '1; m_tready = 1;
        sb = stbQ.size(); bb = datQ.size(); d0 = doneCnt;
        pulseStart();
        waitState(3'd4, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_latency_reached got=0 exp=1"); end
        @(posedge sysClk); #1 abort = 1;
        @(posedge sysClk); #1 abort = 0;
        @(negedge sysClk);
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL abort_state got=%0d exp=6", state); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL abort_tvalid got=%0b exp=0", m_tvalid); end
        checks++; if (sysCsrStrobe !== 4'b1001 || GPIO_OUT !== 32'd0) begin failures++; $display("FAIL abort_disarm got=%0b/%0h exp=1001/0", sysCsrStrobe, GPIO_OUT); end
        @(negedge sysClk);
        checks++; if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0d/%0b exp=0/0", state, busy); end
        repeat (5) @(posedge sysClk);
        #1;
        checks++; if (doneCnt - d0 !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", doneCnt - d0); end
        checks++; if (datQ.size() - bb !== 0) begin failures++; $display("FAIL abort_no_beats got=%0d exp=0", datQ.size() - bb); end
        checks++; if (stbQ.size() - sb !== 3) begin failures++; $display("FAIL abort_strobe_count got=%0d exp=3", stbQ.size() - sb); end
    endtask

    task automatic test_zero_enable();
        int sb, d0;
        doReset();
        sb = stbQ.size(); d0 = doneCnt;
        abort = 1;
        @(posedge sysClk); #1 abort = 0;
        @(negedge sysClk);
        checks++; if (state !== 3'd0 || sysCsrStrobe !== 4'd0) begin failures++; $display("FAIL idle_abort got=%0d/%0b exp=0/0", state, sysCsrStrobe); end
        @(posedge sysClk); #1;
        chanEnable = 4'b0000;
        pulseStart();
        @(negedge sysClk);
        checks++; if (state !== 3'd7 || done !== 1'b0) begin failures++; $display("FAIL zero_done_state got=%0d/%0b exp=7/0", state, done); end
        @(negedge sysClk);
        checks++; if (done !== 1'b1 || state !== 3'd0) begin failures++; $display("FAIL zero_done_pulse got=%0b/%0d exp=1/0", done, state); end
        @(posedge sysClk); #1;
        checks++; if (stbQ.size() - sb !== 0) begin failures++; $display("FAIL zero_no_strobes got=%0d exp=0", stbQ.size() - sb); end
        checks++; if (doneCnt - d0 !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", doneCnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int sbs;
        doReset();
        chanEnable = 4'b0001; readStart = 31'd3; readCount = 24'd2; fullBits = '1; m_tready = 0;
        pulseStart();
        waitState(3'd5, 50, ok);
        checks++; if (!ok || m_tvalid !== 1'b1) begin failures++; $display("FAIL midreset_output got=%0b exp=1", m_tvalid); end
        sbs = stbQ.size();
        #2 sysReset_n = 0;
        #1;
        checks++; if (state !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_async got=%0d/%0b exp=0/0", state, busy); end
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0) begin failures++; $display("FAIL midreset_stream got=%0b/%0h exp=0/0", m_tvalid, m_tdata); end
        repeat (3) @(posedge sysClk);
        #1 sysReset_n = 1; m_tready = 1;
        repeat (5) @(posedge sysClk);
        #1;
        checks++; if (stbQ.size() !== sbs) begin failures++; $display("FAIL midreset_no_disarm got=%0d exp=%0d", stbQ.size(), sbs); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL midreset_idle got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_stall();
        test_abort();
        test_zero_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
